// File: rtl/fixed_accumulate.sv
// Frame accumulator for signed fixed-point samples: sums up to LENGTH samples,
// applies a round-half-up arithmetic right shift, and saturates to BITS.
module fixed_accumulate #(
  parameter int    BITS      = 8,
  parameter string PRECISION = "FIXED_4_4",
  parameter int    LENGTH    = 16,
  parameter int    SHIFT     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [BITS-1:0]         d,
  input  logic                           in_last,
  output logic                           out_valid,
  output logic signed [BITS-1:0]         c,
  output logic                           sat,
  output logic [$clog2(LENGTH+1)-1:0]    count
);

  localparam int CW       = $clog2(LENGTH + 1);
  localparam int ACC_BITS = BITS + $clog2(LENGTH) + 1;
  // One spare bit so adding the rounding constant can never wrap.
  localparam int RW       = ACC_BITS + 1;

  localparam logic signed [RW-1:0] HALF  = (RW'(1) << SHIFT) >> 1;
  localparam logic signed [RW-1:0] MAX_R = RW'((2 ** (BITS - 1)) - 1);
  localparam logic signed [RW-1:0] MIN_R = RW'(-(2 ** (BITS - 1)));

  // The format tag is descriptive only and never alters the arithmetic.
  if (PRECISION == "") begin : g_untagged
  end

  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       out_valid_q, out_valid_d;
  logic signed [BITS-1:0]     c_q, c_d;
  logic                       sat_q, sat_d;

  logic signed [ACC_BITS-1:0] sum;
  logic signed [RW-1:0]       rnd;
  logic                       final_sample;

  always_comb begin
    sum          = acc_q + ACC_BITS'(d);
    rnd          = (RW'(sum) + HALF) >>> SHIFT;
    final_sample = in_valid && (in_last || (count_q == CW'(LENGTH - 1)));

    acc_d       = acc_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    c_d         = c_q;
    sat_d       = sat_q;

    if (in_valid) begin
      if (final_sample) begin
        acc_d       = '0;
        count_d     = '0;
        out_valid_d = 1'b1;
        if (rnd > MAX_R) begin
          c_d   = MAX_R[BITS-1:0];
          sat_d = 1'b1;
        end else if (rnd < MIN_R) begin
          c_d   = MIN_R[BITS-1:0];
          sat_d = 1'b1;
        end else begin
          c_d   = rnd[BITS-1:0];
          sat_d = 1'b0;
        end
      end else begin
        acc_d   = sum;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign sat       = sat_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fixed_accumulate.sv
// Directed and random checks of fixed_accumulate over three parameter sets
// sharing one stimulus stream.
module tb_fixed_accumulate;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic signed [7:0] d = '0;

  logic              ov_a, sat_a, ov_b, sat_b, ov_c, sat_c;
  logic signed [7:0] c_a, c_b, c_c;
  logic [2:0]        cnt_a, cnt_b;
  logic [4:0]        cnt_c;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fixed_accumulate #(.BITS(8), .PRECISION("FIXED_4_4"), .LENGTH(4), .SHIFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d(d), .in_last(in_last),
    .out_valid(ov_a), .c(c_a), .sat(sat_a), .count(cnt_a));

  fixed_accumulate #(.BITS(8), .PRECISION("FIXED_4_4"), .LENGTH(4), .SHIFT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d(d), .in_last(in_last),
    .out_valid(ov_b), .c(c_b), .sat(sat_b), .count(cnt_b));

  fixed_accumulate #(.BITS(8), .PRECISION("FIXED_4_4"), .LENGTH(16), .SHIFT(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d(d), .in_last(in_last),
    .out_valid(ov_c), .c(c_c), .sat(sat_c), .count(cnt_c));

  // Behavioural reference: exact integer sum, round-half-up shift, clip.
  int ll [3] = '{4, 4, 16};
  int ss [3] = '{0, 2, 4};
  int m_acc [3];
  int m_cnt [3];
  int m_c   [3];
  bit m_ov  [3];
  bit m_sat [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_c[i] = 0; m_ov[i] = 0; m_sat[i] = 0;
      end else begin
        m_ov[i] = 0;
        if (in_valid) begin
          int s, r, half;
          s = m_acc[i] + int'(d);
          if (in_last || m_cnt[i] == ll[i] - 1) begin
            half = (ss[i] > 0) ? (1 << (ss[i] - 1)) : 0;
            r = (s + half) >>> ss[i];
            if (r > 127) begin
              m_c[i] = 127; m_sat[i] = 1;
            end else if (r < -128) begin
              m_c[i] = -128; m_sat[i] = 1;
            end else begin
              m_c[i] = r; m_sat[i] = 0;
            end
            m_acc[i] = 0; m_cnt[i] = 0; m_ov[i] = 1;
          end else begin
            m_acc[i] = s;
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Entered and left on a falling edge; outputs then reflect the rising edge.
  task automatic cycle(input bit v, input int dv, input bit last);
    in_valid = v;
    d        = 8'(dv);
    in_last  = last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(1'b0, 0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic check_a(input string tag, input int ov, input int cv, input int sv, input int cnt);
    check({tag, ".ov"},  int'(ov_a),  ov);
    check({tag, ".c"},   int'(c_a),   cv);
    check({tag, ".sat"}, int'(sat_a), sv);
    check({tag, ".cnt"}, int'(cnt_a), cnt);
  endtask

  task automatic check_b(input string tag, input int cv, input int sv);
    check({tag, ".ov"},  int'(ov_b),  1);
    check({tag, ".c"},   int'(c_b),   cv);
    check({tag, ".sat"}, int'(sat_b), sv);
  endtask

  task automatic check_model(input int i);
    int ov, cv, sv, cnt;
    case (i)
      0:       begin ov = int'(ov_a); cv = int'(c_a); sv = int'(sat_a); cnt = int'(cnt_a); end
      1:       begin ov = int'(ov_b); cv = int'(c_b); sv = int'(sat_b); cnt = int'(cnt_b); end
      default: begin ov = int'(ov_c); cv = int'(c_c); sv = int'(sat_c); cnt = int'(cnt_c); end
    endcase
    check($sformatf("rnd%0d.ov", i),  ov,  int'(m_ov[i]));
    check($sformatf("rnd%0d.cnt", i), cnt, m_cnt[i]);
    if (m_ov[i]) begin
      check($sformatf("rnd%0d.c", i),   cv, m_c[i]);
      check($sformatf("rnd%0d.sat", i), sv, int'(m_sat[i]));
    end
  endtask

  int basic [4] = '{10, 20, 30, 40};
  int rnd_in [3][4] = '{'{1, 2, 3, 4}, '{-1, -2, -3, -4}, '{1, 0, 0, 1}};
  int rnd_exp [3] = '{3, -2, 1};

  initial begin
    @(negedge clk);
    do_reset();
    check_a("reset", 0, 0, 0, 0);

    // Basic sum of a full frame
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, basic[k], 1'b0);
      if (k < 3) begin
        check("basic.ov", int'(ov_a), 0);
        check("basic.cnt", int'(cnt_a), k + 1);
      end
    end
    check_a("basic.res", 1, 100, 0, 0);
    cycle(1'b0, 0, 1'b0);
    check_a("basic.hold", 0, 100, 0, 0);

    // Saturation in both directions, frames back-to-back
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, (k < 4) ? 100 : -100, 1'b0);
      if (k == 3) begin
        check_a("sat.pos", 1, 127, 1, 0);
        check_b("sat.pos.b", 100, 0);
      end
      if (k == 7) begin
        check_a("sat.neg", 1, -128, 1, 0);
        check_b("sat.neg.b", -100, 0);
      end
    end

    // Round-half-up with SHIFT=2
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) cycle(1'b1, rnd_in[f][k], 1'b0);
      check_b($sformatf("round%0d", f), rnd_exp[f], 0);
    end

    // Early termination with gaps; in_last without in_valid is ignored
    cycle(1'b1, 5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 99, 1'b1);
      check("gap.ov", int'(ov_a), 0);
      check("gap.cnt", int'(cnt_a), 1);
    end
    cycle(1'b1, 6, 1'b1);
    check_a("early", 1, 11, 0, 0);
    cycle(1'b1, 7, 1'b1);
    check_a("single", 1, 7, 0, 0);
    cycle(1'b0, 0, 1'b0);
    check("single.drop", int'(ov_a), 0);

    // in_last on the LENGTH-th sample closes exactly one frame
    for (int k = 0; k < 4; k++) cycle(1'b1, 1, k == 3);
    check_a("coinc", 1, 4, 0, 0);
    cycle(1'b1, 1, 1'b0);
    check_a("coinc.next", 0, 4, 0, 1);
    cycle(1'b1, 2, 1'b1);
    check_a("coinc.close", 1, 3, 0, 0);

    // Reset mid-frame discards the partial sum and takes priority over in_valid
    cycle(1'b1, 50, 1'b0);
    cycle(1'b1, 50, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 77, 1'b1);
    rst_n = 1'b1;
    check_a("rst.mid", 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, k, 1'b0);
      if (k < 4) check("rst.noov", int'(ov_a), 0);
    end
    check_a("rst.res", 1, 10, 0, 0);

    // Random regression against the reference model on all three instances
    do_reset();
    for (int n = 0; n < 14000; n++) begin
      cycle($urandom_range(0, 7) != 0, int'($urandom_range(0, 255)) - 128,
            $urandom_range(0, 9) == 0);
      for (int i = 0; i < 3; i++) check_model(i);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
